// File: rtl/digit_scroller.sv
// digit_scroller: marquee window over a fixed digit sequence shown
// on NUM_DISP active-low seven-segment displays (8'hFF = blank).

module seven_segment_driver (
   input  logic [3:0] digit,
   input  logic       blank,
   output logic [7:0] seg
);

   always_comb begin
      seg = 8'hFF;
      if (!blank) begin
         unique case (digit)
            4'd0:    seg = 8'hC0;
            4'd1:    seg = 8'hF9;
            4'd2:    seg = 8'hA4;
            4'd3:    seg = 8'hB0;
            4'd4:    seg = 8'h99;
            4'd5:    seg = 8'h92;
            4'd6:    seg = 8'h82;
            4'd7:    seg = 8'hF8;
            4'd8:    seg = 8'h80;
            4'd9:    seg = 8'h90;
            default: seg = 8'hFF;
         endcase
      end
   end

endmodule

module digit_scroller #(
   parameter int                   NUM_DISP    = 6,
   parameter int                   SEQ_LEN     = 9,
   parameter logic [4*SEQ_LEN-1:0] SEQ         = 36'h876543210,
   parameter int                   TICK_CYCLES = 25000000,
   localparam int                  PW = $clog2(SEQ_LEN + NUM_DISP)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [SEQ_LEN-1:0]    SW,
   input  logic                  run,
   input  logic                  dir,
   output logic [8*NUM_DISP-1:0] DISP,
   output logic [PW-1:0]         pos,
   output logic                  wrap
);

   localparam int L  = SEQ_LEN + NUM_DISP;
   localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(TICK_CYCLES - 1);
   localparam logic [PW-1:0] LAST    = PW'(L - 1);

   logic [CW-1:0]         cnt;
   logic                  tick;
   logic [PW-1:0]         sel;
   logic                  blank_all;
   logic [8*NUM_DISP-1:0] seg_all;

   assign tick      = run && (cnt == CNT_MAX);
   assign blank_all = !run && (SW == '0);

   // Lowest set switch wins.
   always_comb begin
      sel = '0;
      for (int i = SEQ_LEN - 1; i >= 0; i--) begin
         if (SW[i]) sel = PW'(i);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         pos  <= '0;
         wrap <= 1'b0;
         DISP <= '1;
      end else begin
         wrap <= 1'b0;
         DISP <= seg_all;
         if (run) begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
               if (!dir) begin
                  pos  <= (pos == LAST) ? '0 : pos + 1'b1;
                  wrap <= (pos == LAST);
               end else begin
                  pos  <= (pos == '0) ? LAST : pos - 1'b1;
                  wrap <= (pos == '0);
               end
            end
         end else begin
            cnt <= '0;
            if (SW != '0) pos <= sel;
         end
      end
   end

   for (genvar k = 0; k < NUM_DISP; k++) begin : gen_disp
      localparam logic [PW:0] OFF  = (PW+1)'(NUM_DISP - 1 - k);
      localparam logic [PW:0] LW   = (PW+1)'(L);
      localparam logic [PW:0] SLW  = (PW+1)'(SEQ_LEN);
      logic [PW:0] sum;
      logic [PW:0] idx;
      logic        in_seq;
      logic [3:0]  digit;

      // Index into the virtual stream, wrapped modulo L.
      assign sum    = {1'b0, pos} + OFF;
      assign idx    = (sum >= LW) ? sum - LW : sum;
      assign in_seq = (idx < SLW);
      assign digit  = in_seq ? 4'(SEQ >> {idx, 2'b00}) : 4'hF;

      seven_segment_driver u_seg (
         .digit (digit),
         .blank (blank_all || !in_seq),
         .seg   (seg_all[8*k +: 8])
      );
   end

endmodule

// File: tb/tb_digit_scroller.sv
// Bench for digit_scroller: TICK_CYCLES=4 and TICK_CYCLES=1 instances
// driven together and compared against a behavioural stream model.

module tb_digit_scroller;

   localparam int SL = 3;
   localparam int ND = 2;
   localparam int L  = SL + ND;
   localparam logic [11:0] SQ = 12'h321;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  sw = '0;
   logic        run = 1'b0;
   logic        dir = 1'b0;
   logic [15:0] disp4, disp1;
   logic [2:0]  pos4, pos1;
   logic        wrap4, wrap1;

   int n_chk  = 0;
   int n_pass = 0;

   int          tc[2] = '{4, 1};
   int          m_rc[2];
   int          m_pos[2];
   bit          m_wrap[2];
   logic [15:0] m_disp[2];

   always #5 clk = ~clk;

   digit_scroller #(
      .NUM_DISP(ND), .SEQ_LEN(SL), .SEQ(SQ), .TICK_CYCLES(4)
   ) dut4 (
      .clk(clk), .rst_n(rst_n), .SW(sw), .run(run), .dir(dir),
      .DISP(disp4), .pos(pos4), .wrap(wrap4)
   );

   digit_scroller #(
      .NUM_DISP(ND), .SEQ_LEN(SL), .SEQ(SQ), .TICK_CYCLES(1)
   ) dut1 (
      .clk(clk), .rst_n(rst_n), .SW(sw), .run(run), .dir(dir),
      .DISP(disp1), .pos(pos1), .wrap(wrap1)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [7:0] seg_of(input int d);
      case (d)
         0: return 8'hC0;
         1: return 8'hF9;
         2: return 8'hA4;
         3: return 8'hB0;
         4: return 8'h99;
         5: return 8'h92;
         6: return 8'h82;
         7: return 8'hF8;
         8: return 8'h80;
         9: return 8'h90;
         default: return 8'hFF;
      endcase
   endfunction

   // Stream value at j; 15 stands for blank.
   function automatic int stream_digit(input int j);
      logic [11:0] s;
      s = SQ;
      if (j < SL) return int'(s[4*j +: 4]);
      return 15;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_rc[i]   = 0;
         m_pos[i]  = 0;
         m_wrap[i] = 0;
         m_disp[i] = 16'hFFFF;
      end
   endtask

   task automatic model_edge();
      for (int i = 0; i < 2; i++) begin
         if (!rst_n) begin
            m_rc[i]   = 0;
            m_pos[i]  = 0;
            m_wrap[i] = 0;
            m_disp[i] = 16'hFFFF;
         end else begin
            if (!run && sw == 0) m_disp[i] = 16'hFFFF;
            else m_disp[i] = {seg_of(stream_digit(m_pos[i])),
                              seg_of(stream_digit((m_pos[i] + 1) % L))};
            m_wrap[i] = 0;
            if (run) begin
               if (m_rc[i] % tc[i] == tc[i] - 1) begin
                  if (dir) begin
                     m_wrap[i] = (m_pos[i] == 0);
                     m_pos[i]  = (m_pos[i] + L - 1) % L;
                  end else begin
                     m_wrap[i] = (m_pos[i] == L - 1);
                     m_pos[i]  = (m_pos[i] + 1) % L;
                  end
               end
               m_rc[i]++;
            end else begin
               m_rc[i] = 0;
               for (int b = SL - 1; b >= 0; b--)
                  if (sw[b]) m_pos[i] = b;
            end
         end
      end
   endtask

   task automatic compare_all();
      chk("pos_t4",  pos4,  m_pos[0]);
      chk("wrap_t4", wrap4, m_wrap[0]);
      chk("disp_t4", disp4, m_disp[0]);
      chk("pos_t1",  pos1,  m_pos[1]);
      chk("wrap_t1", wrap1, m_wrap[1]);
      chk("disp_t1", disp1, m_disp[1]);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
      @(negedge clk);
   endtask

   // Assert reset between edges and check it lands immediately.
   task automatic async_reset();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("async_pos",  pos4,  0);
      chk("async_wrap", wrap4, 0);
      chk("async_disp", disp4, 16'hFFFF);
      compare_all();
      cycle();
      run   = 1'b0;
      sw    = '0;
      rst_n = 1'b1;
   endtask

   initial begin
      repeat (2) cycle();
      rst_n = 1'b1;
      repeat (3) cycle();

      sw = 3'b110;
      cycle();
      chk("man_pos1", pos4, 1);
      cycle();
      chk("man_disp1", disp4, {seg_of(2), seg_of(3)});
      sw = 3'b001;
      repeat (2) cycle();
      chk("man_pos0", pos4, 0);
      chk("man_disp0", disp4, {seg_of(1), seg_of(2)});
      sw = 3'b000;
      repeat (2) cycle();
      chk("man_blank", disp4, 16'hFFFF);
      chk("man_hold", pos4, 0);

      run = 1'b1;
      dir = 1'b0;
      for (int c = 0; c < 24; c++) begin
         sw = 3'($urandom);
         cycle();
      end

      async_reset();
      repeat (2) cycle();

      run = 1'b1;
      dir = 1'b1;
      repeat (10) cycle();
      dir = 1'b0;
      repeat (8) cycle();

      run = 1'b0;
      sw  = 3'b100;
      repeat (2) cycle();
      run = 1'b1;
      repeat (6) cycle();

      for (int c = 0; c < 400; c++) begin
         run = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 7) == 0) dir = ~dir;
         sw = 3'($urandom);
         if ($urandom_range(0, 99) == 0) async_reset();
         else cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
